// File: rtl/ps2_key_pkg.sv
// Shared scan-code constants, decoder state type and direction indices for
// the PS/2 movement-key tracker.
package ps2_key_pkg;

  localparam logic [7:0] SC_F0        = 8'hF0;
  localparam logic [7:0] SC_E0        = 8'hE0;
  localparam logic [7:0] SC_W         = 8'h1D;
  localparam logic [7:0] SC_A         = 8'h1C;
  localparam logic [7:0] SC_S         = 8'h1B;
  localparam logic [7:0] SC_D         = 8'h23;
  localparam logic [7:0] SC_R         = 8'h2D;
  localparam logic [7:0] SC_EXT_UP    = 8'h75;
  localparam logic [7:0] SC_EXT_DOWN  = 8'h72;
  localparam logic [7:0] SC_EXT_LEFT  = 8'h6B;
  localparam logic [7:0] SC_EXT_RIGHT = 8'h74;

  localparam int NUM_DIRS  = 4;
  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  typedef logic [NUM_DIRS-1:0] dir_mask_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } dec_state_e;

  // One-hot direction for a plain (non-E0) code; zero when unmapped.
  function automatic dir_mask_t plain_dir(input logic [7:0] code);
    dir_mask_t m;
    m = '0;
    case (code)
      SC_W:    m[DIR_UP]    = 1'b1;
      SC_S:    m[DIR_DOWN]  = 1'b1;
      SC_A:    m[DIR_LEFT]  = 1'b1;
      SC_D:    m[DIR_RIGHT] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  // One-hot direction for the byte following an E0 prefix.
  function automatic dir_mask_t ext_dir(input logic [7:0] code);
    dir_mask_t m;
    m = '0;
    case (code)
      SC_EXT_UP:    m[DIR_UP]    = 1'b1;
      SC_EXT_DOWN:  m[DIR_DOWN]  = 1'b1;
      SC_EXT_LEFT:  m[DIR_LEFT]  = 1'b1;
      SC_EXT_RIGHT: m[DIR_RIGHT] = 1'b1;
      default:      m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_key_tracker_step_timer.sv
// Free-running step divider 0..STEP_DIV-1 with synchronous restart; tc_o is
// high for the one cycle the count sits at its terminal value.
module step_timer #(
  parameter int unsigned STEP_DIV = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tc_o
);

  logic [31:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == 32'(STEP_DIV - 1));

  // Terminal count is still reported in a restart cycle so held keys pulse.
  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (restart_i || tc_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code decoder tracking held movement keys and emitting
// rate-limited step pulses plus a home pulse for R.
module ps2_key_tracker
  import ps2_key_pkg::*;
#(
  parameter int unsigned STEP_DIV       = 500000,
  parameter int unsigned PREFIX_TIMEOUT = 4096
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic [7:0] ps2_data,
  input  logic       ps2_key_pressed,
  output logic [3:0] oKEY_HELD,
  output logic [3:0] oSTEP,
  output logic       oHOME
);

  dec_state_e  state_q, state_d;
  logic [31:0] tmo_q, tmo_d;
  dir_mask_t   held_q, held_d;
  dir_mask_t   step_q, step_d;
  logic        home_q, home_d;

  dir_mask_t   make_mask, brk_mask, new_mask, step_raw, suppress;
  logic        restart, tc;

  step_timer #(.STEP_DIV(STEP_DIV)) u_step_timer (
    .clk_i     (iVGA_CLK),
    .rst_ni    (iRST_n),
    .restart_i (restart),
    .tc_o      (tc)
  );

  // Decoder FSM and prefix timeout.
  always_comb begin
    state_d   = state_q;
    tmo_d     = '0;
    make_mask = '0;
    brk_mask  = '0;
    home_d    = 1'b0;
    if (ps2_key_pressed) begin
      case (state_q)
        ST_IDLE: begin
          if (ps2_data == SC_F0)      state_d = ST_BRK;
          else if (ps2_data == SC_E0) state_d = ST_EXT;
          else begin
            make_mask = plain_dir(ps2_data);
            home_d    = (ps2_data == SC_R);
          end
        end
        ST_BRK: begin
          if (ps2_data != SC_F0) begin
            brk_mask = plain_dir(ps2_data);
            state_d  = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (ps2_data == SC_F0)      state_d = ST_EXT_BRK;
          else if (ps2_data != SC_E0) begin
            make_mask = ext_dir(ps2_data);
            state_d   = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (ps2_data != SC_F0) begin
            brk_mask = ext_dir(ps2_data);
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // A lost follow-up byte must not leave the decoder stuck mid-sequence.
      if (tmo_q == 32'(PREFIX_TIMEOUT - 1)) state_d = ST_IDLE;
      else                                  tmo_d   = tmo_q + 32'd1;
    end
  end

  // Held mask and step pulse generation.
  always_comb begin
    new_mask = make_mask & ~held_q;
    held_d   = (held_q | make_mask) & ~brk_mask;
    restart  = |new_mask;
    step_raw = new_mask | (tc ? held_d : '0);
    suppress = '0;
    if (held_d[DIR_UP] && held_d[DIR_DOWN]) begin
      suppress[DIR_UP]   = 1'b1;
      suppress[DIR_DOWN] = 1'b1;
    end
    if (held_d[DIR_LEFT] && held_d[DIR_RIGHT]) begin
      suppress[DIR_LEFT]  = 1'b1;
      suppress[DIR_RIGHT] = 1'b1;
    end
    step_d = step_raw & ~suppress;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
      held_q  <= '0;
      step_q  <= '0;
      home_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      held_q  <= held_d;
      step_q  <= step_d;
      home_q  <= home_d;
    end
  end

  assign oKEY_HELD = held_q;
  assign oSTEP     = step_q;
  assign oHOME     = home_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench: stimulus queues expected output events by cycle; a
// negedge monitor pops one per observed event (step, home or held change).
module tb_ps2_key_tracker;

  localparam int unsigned SD = 8;
  localparam int unsigned PT = 16;

  logic       clk, rst_n;
  logic [7:0] data;
  logic       strobe;
  logic [3:0] held, step;
  logic       home;

  typedef struct {
    int       cyc;
    logic [3:0] held;
    logic [3:0] step;
    logic     home;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  ps2_key_tracker #(.STEP_DIV(SD), .PREFIX_TIMEOUT(PT)) dut (
    .iVGA_CLK        (clk),
    .iRST_n          (rst_n),
    .ps2_data        (data),
    .ps2_key_pressed (strobe),
    .oKEY_HELD       (held),
    .oSTEP           (step),
    .oHOME           (home)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [3:0] h, input logic [3:0] s, input logic hm);
    ev_t e;
    e.cyc = c; e.held = h; e.step = s; e.home = hm;
    q.push_back(e);
  endtask

  // Called at #1 after a posedge; leaves the bench at #1 after posedge cyc+2.
  task automatic send(input logic [7:0] b);
    data = b; strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) idle(1);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor
  initial begin
    logic [3:0] prev;
    ev_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev = held;
      else if (step != 4'b0 || home || held != prev) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected event cyc=%0d held=%b step=%b home=%b", cyc, held, step, home);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.held !== held || e.step !== step || e.home !== home) begin
            n_bad++;
            $display("FAIL event: got cyc=%0d held=%b step=%b home=%b expected cyc=%0d held=%b step=%b home=%b",
                     cyc, held, step, home, e.cyc, e.held, e.step, e.home);
          end
        end
        prev = held;
      end
    end
  end

  initial begin
    int b;
    rst_n = 1'b0; data = 8'h00; strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held", held, 4'b0);
    chk("reset_step", step, 4'b0);
    chk("reset_home", {3'b0, home}, 4'b0);
    rst_n = 1'b1;
    idle(2);

    // Up make, periodic repeat every SD cycles, then break.
    b = cyc;
    push(b + 1, 4'b0001, 4'b0001, 1'b0);
    push(b + 9, 4'b0001, 4'b0001, 1'b0);
    push(b + 17, 4'b0001, 4'b0001, 1'b0);
    send(8'h1D);
    goto_cyc(b + 18);
    push(b + 21, 4'b0000, 4'b0000, 1'b0);
    send(8'hF0); send(8'h1D);
    idle(12);

    // Extended left, plain-left repeats do not restart the divider.
    b = cyc;
    push(b + 3, 4'b0100, 4'b0100, 1'b0);
    push(b + 11, 4'b0100, 4'b0100, 1'b0);
    push(b + 15, 4'b0000, 4'b0000, 1'b0);
    send(8'hE0); send(8'h6B);
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h6B);
    idle(12);

    // Opposing up/down suppress steps; releasing down resumes up.
    b = cyc;
    push(b + 1, 4'b0001, 4'b0001, 1'b0);
    push(b + 3, 4'b0011, 4'b0000, 1'b0);
    send(8'h1D); send(8'h1B);
    goto_cyc(b + 14);
    push(b + 17, 4'b0001, 4'b0000, 1'b0);
    push(b + 19, 4'b0001, 4'b0001, 1'b0);
    send(8'hF0); send(8'h1B);
    goto_cyc(b + 20);
    push(b + 23, 4'b0000, 4'b0000, 1'b0);
    send(8'hF0); send(8'h1D);
    idle(12);

    // Break prefix times out; following byte is a make.
    b = cyc;
    send(8'hF0);
    goto_cyc(b + 20);
    push(b + 21, 4'b1000, 4'b1000, 1'b0);
    push(b + 25, 4'b0000, 4'b0000, 1'b0);
    send(8'h23); send(8'hF0); send(8'h23);
    idle(12);

    // Home on every make, not on break; double F0 still a break.
    b = cyc;
    push(b + 1, 4'b0000, 4'b0000, 1'b1);
    push(b + 3, 4'b0000, 4'b0000, 1'b1);
    push(b + 9, 4'b0001, 4'b0001, 1'b0);
    push(b + 15, 4'b0000, 4'b0000, 1'b0);
    send(8'h2D); send(8'h2D); send(8'hF0); send(8'h2D);
    send(8'h1D); send(8'hF0); send(8'hF0); send(8'h1D);
    idle(12);

    // Reset mid-E0 with right held; afterwards bare 74 is unmapped.
    b = cyc;
    push(b + 3, 4'b1000, 4'b1000, 1'b0);
    send(8'hE0); send(8'h74); send(8'hE0);
    rst_n = 1'b0;
    #1;
    chk("midrst_held", held, 4'b0);
    chk("midrst_step", step, 4'b0);
    chk("midrst_home", {3'b0, home}, 4'b0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send(8'h74);
    idle(12);
    b = cyc;
    push(b + 3, 4'b1000, 4'b1000, 1'b0);
    push(b + 9, 4'b0000, 4'b0000, 1'b0);
    send(8'hE0); send(8'h74); send(8'hE0); send(8'hF0); send(8'h74);
    idle(20);

    while (q.size() > 0) begin
      ev_t e;
      e = q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL missing event: got none expected cyc=%0d held=%b step=%b home=%b",
               e.cyc, e.held, e.step, e.home);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Decodes the PS/2 scan-code byte stream (make, `F0` break and `E0` extended prefixes) into a held-key mask for the movement keys. It then converts held keys into rate-limited one-cycle step pulses. It sits between the PS/2 receiver and the VGA block-drawing controller. It replaces "last byte received" polling with true press/release tracking, so the block moves only while a key is physically held.

## Interface
- `STEP_DIV`, 500000: cycles between repeat step pulses while a key is held; minimum 2.
- `PREFIX_TIMEOUT`, 4096: cycles allowed between a prefix byte and its following byte.
- `iVGA_CLK  in  1`: sole clock, rising-edge.
- `iRST_n  in  1`: reset; asynchronous, active-low.
- `ps2_data  in  8`: received scan-code byte; valid only when `ps2_key_pressed` is 1.
- `ps2_key_pressed  in  1`: one-cycle strobe, one per received byte.
- `oKEY_HELD  out  4`: held mask; bit0 up, bit1 down, bit2 left, bit3 right.
- `oSTEP  out  4`: one-cycle step pulses, same bit order as `oKEY_HELD`.
- `oHOME  out  1`: one-cycle pulse on a make of R (`2D`).

## Operation
- **Key map, plain codes:** up `1D` (W), left `1C` (A), down `1B` (S), right `23` (D), home `2D` (R).
- **Key map, extended codes:** up `E0 75`, down `E0 72`, left `E0 6B`, right `E0 74`.
- Plain and extended codes for the same direction set and clear the same bit.
- **Decoder FSM states:** IDLE, BRK, EXT, EXT_BRK.
- **From IDLE:**
  - `F0` → BRK.
  - `E0` → EXT.
  - Any other byte is a make → IDLE.
- **From BRK:**
  - `F0` stays in BRK.
  - Any other byte is a break → IDLE.
- **From EXT:**
  - `F0` → EXT_BRK.
  - `E0` stays in EXT.
  - Any other byte is an extended make → IDLE.
- **From EXT_BRK:** any byte except `F0` is an extended break → IDLE.
- Unmapped makes and breaks change nothing except the FSM state.
- **Prefix timeout:** in BRK, EXT or EXT_BRK, if `PREFIX_TIMEOUT` cycles pass with no strobe, return to IDLE; no key change.
- **Make of a direction not currently held:**
  - Set its bit.
  - Pulse its `oSTEP` bit immediately.
  - Restart the step divider at 0.
- **Make of a direction already held** (typematic repeat): ignored; no pulse, no divider restart.
- **Break:** clears the bit; no pulse. A break of an unheld key is a no-op.
- **Step divider:**
  - Free-running 0..`STEP_DIV`-1, 32-bit.
  - At terminal count it pulses every held direction bit.
- **Opposing pairs:** if both up and down are held, both `oSTEP` bits are suppressed. The same rule applies to left and right. `oKEY_HELD` still shows both bits.
- **Home:** a make of R pulses `oHOME` on every make, including typematic repeats. The break of R is ignored.

## Timing
- All outputs are registered.
- Reset values: `oKEY_HELD` = 0, `oSTEP` = 0, `oHOME` = 0, FSM = IDLE, divider = 0, timeout counter = 0.
- Latency: a strobe in cycle N updates `oKEY_HELD`, the immediate `oSTEP` pulse and `oHOME` in cycle N+1.
- A new make coinciding with divider terminal count:
  - Divider restarts.
  - The pulse for already-held keys still fires that cycle.
  - `oSTEP` is the OR of immediate and periodic pulses; each bit is at most one cycle per event.
- Strobes are at least 2 cycles apart. Back-to-back strobes are still accepted and each is processed in order, one per cycle.
- Reset mid-prefix or while keys are held clears everything. Keys physically held at reset are not seen again until their next make.

## Structure
- **Package `ps2_key_pkg`:**
  - Scan-code constants: `F0`, `E0`, the 5 plain codes, the 4 extended codes.
  - FSM state typedef.
  - Direction index constants: UP=0, DOWN=1, LEFT=2, RIGHT=3.
- **Sub-module `step_timer`:**
  - Divider with synchronous restart input and terminal-count output.
  - Parameter `STEP_DIV`.
- Decoder FSM, timeout counter and held-mask register stay in the top module.

## Test plan
- `1D` strobe: `oKEY_HELD`=0001 and `oSTEP`=0001 one cycle later. With `STEP_DIV`=8, `oSTEP`[0] repeats every 8 cycles. After `F0 1D`, `oKEY_HELD`=0000 and no further pulses.
- `E0 6B`, then `1C` repeated 3 times: exactly one immediate pulse on bit2; divider not restarted by repeats. Then `E0 F0 6B`: bit2 cleared.
- Hold `1D` and `1B` together: `oKEY_HELD`=0011 and `oSTEP` stays 0 at terminal counts. Release `1B`: pulses resume on bit0.
- `F0`, then silence for `PREFIX_TIMEOUT` cycles, then `23`: treated as a make, so `oKEY_HELD`=1000 and the step pulse fires.
- `2D` twice: two `oHOME` pulses. `F0 2D`: no pulse. `F0 F0 1D`: break of up.
- Assert `iRST_n`=0 mid-`E0` with bit3 held: all outputs 0 immediately. After release, `74` alone is a plain unmapped make with no effect.
